// File: rtl/reg_file_wb_pkg.sv
// Shared types and sizing for the reg_file write-back queue.
// The entry struct is sized by the package localparams, so the module defaults must match them.
package reg_file_wb_pkg;

    localparam int DATA_WIDTH = 3;
    localparam int REG_WIDTH  = 2;
    localparam int DEPTH      = 4;

    typedef struct packed {
        logic [REG_WIDTH-1:0]  addr;
        logic [DATA_WIDTH-1:0] data;
    } wb_entry_t;

    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/reg_file_wb_fwd.sv
// Newest-match search over the occupied queue entries for one read port.
module reg_file_wb_fwd import reg_file_wb_pkg::*; #(
    parameter int DATA_WIDTH = reg_file_wb_pkg::DATA_WIDTH,
    parameter int REG_WIDTH  = reg_file_wb_pkg::REG_WIDTH,
    parameter int DEPTH      = reg_file_wb_pkg::DEPTH,
    localparam int PTR_W     = ptr_w(DEPTH)
) (
    input  wb_entry_t [DEPTH-1:0]  entries,
    input  logic [PTR_W-1:0]       rd_ptr,
    input  logic [PTR_W:0]         count,
    input  logic [REG_WIDTH-1:0]   addr,
    output logic                   hit,
    output logic [DATA_WIDTH-1:0]  data
);

    logic [PTR_W-1:0] idx;

    // Walk oldest to newest so a later match overrides an earlier one.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PTR_W'(i);
            if (((PTR_W+1)'(i) < count) && (entries[idx].addr == addr)) begin
                hit  = 1'b1;
                data = entries[idx].data;
            end
        end
    end

endmodule

// File: rtl/reg_file_wb_queue.sv
// Write-back FIFO in front of reg_file: drains one entry per cycle and
// forwards pending data to both read ports.
module reg_file_wb_queue import reg_file_wb_pkg::*; #(
    parameter int DATA_WIDTH = reg_file_wb_pkg::DATA_WIDTH,
    parameter int REG_WIDTH  = reg_file_wb_pkg::REG_WIDTH,
    parameter int DEPTH      = reg_file_wb_pkg::DEPTH,
    localparam int PTR_W     = ptr_w(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [REG_WIDTH-1:0]  in_addr,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  wr_en,
    output logic [REG_WIDTH-1:0]  wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    input  logic [REG_WIDTH-1:0]  fwd_addr_1,
    input  logic [REG_WIDTH-1:0]  fwd_addr_2,
    output logic                  fwd_hit_1,
    output logic [DATA_WIDTH-1:0] fwd_data_1,
    output logic                  fwd_hit_2,
    output logic [DATA_WIDTH-1:0] fwd_data_2,
    output logic [PTR_W:0]        count
);

    wb_entry_t [DEPTH-1:0] entries;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic                  push;
    logic                  pop;

    // reg_file never back-pressures, so any occupied head pops this cycle.
    assign in_ready = (count != (PTR_W+1)'(DEPTH));
    assign push     = in_valid && in_ready;
    assign pop      = (count != '0);

    assign wr_en   = pop;
    assign wr_addr = pop ? entries[rd_ptr].addr : '0;
    assign wr_data = pop ? entries[rd_ptr].data : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            entries <= '0;
        end else begin
            if (push) begin
                entries[wr_ptr] <= '{addr: in_addr, data: in_data};
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    reg_file_wb_fwd #(
        .DATA_WIDTH(DATA_WIDTH), .REG_WIDTH(REG_WIDTH), .DEPTH(DEPTH)
    ) u_fwd_1 (
        .entries(entries), .rd_ptr(rd_ptr), .count(count),
        .addr(fwd_addr_1), .hit(fwd_hit_1), .data(fwd_data_1)
    );

    reg_file_wb_fwd #(
        .DATA_WIDTH(DATA_WIDTH), .REG_WIDTH(REG_WIDTH), .DEPTH(DEPTH)
    ) u_fwd_2 (
        .entries(entries), .rd_ptr(rd_ptr), .count(count),
        .addr(fwd_addr_2), .hit(fwd_hit_2), .data(fwd_data_2)
    );

endmodule

// File: tb/tb_reg_file_wb_queue.sv
// Randomised bench for reg_file_wb_queue against a queue-based reference model.
module tb_reg_file_wb_queue;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_addr;
    logic [2:0] in_data;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [2:0] wr_data;
    logic [1:0] fwd_addr_1;
    logic [1:0] fwd_addr_2;
    logic       fwd_hit_1;
    logic [2:0] fwd_data_1;
    logic       fwd_hit_2;
    logic [2:0] fwd_data_2;
    logic [2:0] count;

    reg_file_wb_queue dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_data(in_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .fwd_addr_1(fwd_addr_1), .fwd_addr_2(fwd_addr_2),
        .fwd_hit_1(fwd_hit_1), .fwd_data_1(fwd_data_1),
        .fwd_hit_2(fwd_hit_2), .fwd_data_2(fwd_data_2),
        .count(count)
    );

    always #5 clk = ~clk;

    typedef struct { int a; int d; } ent_t;
    ent_t q[$];
    int   rf_exp[4] = '{default: 0};
    int   rf_act[4] = '{default: 0};
    int   n_chk  = 0;
    int   n_pass = 0;

    // Register file as seen through the DUT's write port.
    always @(posedge clk) if (wr_en) rf_act[wr_addr] <= int'(wr_data);

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    function automatic void fwd_exp(input int addr, output int h, output int dd);
        h = 0; dd = 0;
        foreach (q[i]) if (q[i].a == addr) begin h = 1; dd = q[i].d; end
    endfunction

    task automatic check_outputs();
        int h, dd;
        chk("count",    int'(count),    q.size());
        chk("in_ready", int'(in_ready), (q.size() != 4) ? 1 : 0);
        chk("wr_en",    int'(wr_en),    (q.size() != 0) ? 1 : 0);
        chk("wr_addr",  int'(wr_addr),  (q.size() != 0) ? q[0].a : 0);
        chk("wr_data",  int'(wr_data),  (q.size() != 0) ? q[0].d : 0);
        fwd_exp(int'(fwd_addr_1), h, dd);
        chk("fwd_hit_1",  int'(fwd_hit_1),  h);
        chk("fwd_data_1", int'(fwd_data_1), dd);
        fwd_exp(int'(fwd_addr_2), h, dd);
        chk("fwd_hit_2",  int'(fwd_hit_2),  h);
        chk("fwd_data_2", int'(fwd_data_2), dd);
    endtask

    task automatic check_rf();
        for (int r = 0; r < 4; r++) chk($sformatf("rf[%0d]", r), rf_act[r], rf_exp[r]);
    endtask

    // Called at a negedge: drive, check, advance model, return at next negedge.
    task automatic step(input bit v, input int a, input int d, input int f1, input int f2);
        bit do_pop, do_push;
        in_valid = v; in_addr = 2'(a); in_data = 3'(d);
        fwd_addr_1 = 2'(f1); fwd_addr_2 = 2'(f2);
        #1;
        check_outputs();
        do_push = v && (q.size() < 4);
        do_pop  = (q.size() != 0);
        if (do_pop) begin rf_exp[q[0].a] = q[0].d; void'(q.pop_front()); end
        if (do_push) q.push_back('{a, d});
        @(posedge clk);
        @(negedge clk);
    endtask

    // Asynchronous reset asserted mid-cycle with a request still presented.
    task automatic do_reset();
        in_valid = 1'b1; in_addr = 2'($urandom_range(3)); in_data = 3'($urandom_range(7));
        rst = 1'b1;
        #1;
        q.delete();
        check_outputs();
        @(posedge clk);
        @(negedge clk);
        check_outputs();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b1; in_addr = 2'd3; in_data = 3'd7;
        fwd_addr_1 = 2'd3; fwd_addr_2 = 2'd0;
        @(negedge clk);
        @(negedge clk);
        check_outputs();
        rst = 1'b0;
        step(0, 0, 0, 3, 0);              // nothing captured during reset

        // Single write and its forwarding window
        step(1, 1, 5, 1, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        chk("single_rf1", rf_act[1], 5);

        // Back-to-back pushes across the pointer wrap
        for (int i = 1; i <= 5; i++) step(1, i % 4, i, i % 4, (i + 1) % 4);
        step(0, 0, 0, 1, 2);
        check_rf();

        // Two writes to the same register
        step(1, 2, 3, 2, 0);
        step(1, 2, 6, 2, 0);
        step(0, 0, 0, 2, 0);
        step(0, 0, 0, 2, 0);
        chk("same_reg_rf2", rf_act[2], 6);

        // Reset after the first of three writes has committed
        step(1, 0, 1, 0, 1);
        step(1, 1, 2, 1, 0);
        do_reset();
        step(0, 0, 0, 1, 2);
        check_rf();
        chk("mid_reset_rf1", rf_act[1], 5);

        // Random traffic with occasional resets
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(49) == 0) do_reset();
            else step($urandom_range(3) != 0, $urandom_range(3), $urandom_range(7),
                      $urandom_range(3), $urandom_range(3));
        end
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 2, 3);
        check_rf();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
